posit_to_fp_pipe: RTL and testbench

//  Streaming, parametrised posit-to-IEEE-float converter: 3-stage pipeline with valid/ready handshake on both sides.

---
 rtl/posit_to_fp_pipe.sv | 191 +++++++++++++++++++
 tb/tb_posit_to_fp_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_to_fp_pipe.sv
// posit_to_fp_pipe: 3-stage streaming posit -> IEEE float converter (decode, extract, pack) carrying a tag sideband.
// Latency 3 cycles counting the transfer cycle; per-stage valid/ready, bubbles collapse; POSIT2FP_RNE_EN selects RNE over truncation.
module posit_to_fp_pipe #(
   parameter int N  = 32,
   parameter int es = 3,
   parameter int E  = 8,
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic [TW-1:0] out_tag,
   output logic          out_ovf,
   output logic          out_unf
);
   localparam int M  = N - E - 1;
   localparam int FW = N - 1 - es;
   localparam int RB = $clog2(N);
   localparam int SW = $clog2((N - 1) * (2 ** es) + 2 ** E) + 2;
   localparam logic signed [SW-1:0] BIAS_S = SW'(2 ** (E - 1) - 1);
   localparam logic signed [SW-1:0] EMAX_S = SW'(2 ** E - 1);
   localparam logic signed [SW-1:0] ZERO_S = '0;

   logic w_rdy1, w_rdy2, w_rdy3;
   logic r1_v, r2_v, r3_v;

   assign w_rdy3   = out_ready | ~r3_v;
   assign w_rdy2   = w_rdy3 | ~r2_v;
   assign w_rdy1   = w_rdy2 | ~r1_v;
   assign in_ready = w_rdy1;

   // S1: magnitude of the body bits and regime run length
   logic [N-2:0]  w_body, w_y;
   logic [RB-1:0] w_run;
   logic          w_zero, w_nar;

   assign w_body = in_data[N-1] ? -in_data[N-2:0] : in_data[N-2:0];
   assign w_y    = w_body[N-2] ? ~w_body : w_body;
   assign w_zero = (in_data == '0);
   assign w_nar  = (in_data == {1'b1, {(N-1){1'b0}}});

   always_comb begin : p_run
      logic v_found;
      v_found = 1'b0;
      w_run   = RB'(N - 1);
      for (int i = N - 2; i >= 0; i--) begin
         if (!v_found && w_y[i]) begin
            w_run   = RB'(N - 2 - i);
            v_found = 1'b1;
         end
      end
   end

   logic          r1_sign, r1_zero, r1_nar, r1_r0;
   logic [N-2:0]  r1_body;
   logic [RB-1:0] r1_run;
   logic [TW-1:0] r1_tag;

   // S2: strip regime + terminator; bits shifted past the word end read as 0
   logic [RB:0]          w_sh_amt;
   logic [N-2:0]         w_sh;
   logic [es-1:0]        w_e;
   logic [FW-1:0]        w_frac;
   logic signed [SW-1:0] w_run_s, w_k, w_biased;

   assign w_sh_amt = {1'b0, r1_run} + (RB+1)'(1);
   assign w_sh     = r1_body << w_sh_amt;
   assign w_e      = w_sh[N-2 -: es];
   assign w_frac   = w_sh[FW-1:0];
   assign w_run_s  = SW'(r1_run);
   assign w_k      = r1_r0 ? (w_run_s - SW'(1)) : -w_run_s;
   assign w_biased = (w_k <<< es) + SW'(w_e) + BIAS_S;

   logic                 r2_sign, r2_zero, r2_nar;
   logic signed [SW-1:0] r2_biased;
   logic [FW-1:0]        r2_frac;
   logic [TW-1:0]        r2_tag;

   // S3: round, then saturate / flush / specials
   logic [M-1:0]         w_man, w_man_r;
   logic                 w_rnd, w_carry;
   logic signed [SW-1:0] w_exp_r;
   logic [N-1:0]         w_dat;
   logic                 w_ovf, w_unf;

   assign w_man = r2_frac[FW-1 -: M];
`ifdef POSIT2FP_RNE_EN
   logic w_grd, w_stk;
   assign w_grd = r2_frac[FW-M-1];
   assign w_stk = |r2_frac[FW-M-2:0];
   assign w_rnd = w_grd & (w_stk | w_man[0]);
`else
   logic w_unused_lsb;
   assign w_unused_lsb = |r2_frac[FW-M-1:0];
   assign w_rnd        = 1'b0;
`endif
   assign {w_carry, w_man_r} = {1'b0, w_man} + (M+1)'(w_rnd);
   assign w_exp_r = r2_biased + SW'(w_carry);

   always_comb begin
      w_dat = {r2_sign, w_exp_r[E-1:0], w_man_r};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      if (r2_zero) begin
         w_dat = '0;
      end else if (r2_nar) begin
         w_dat = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      end else if (w_exp_r >= EMAX_S) begin
         w_dat = {r2_sign, {E{1'b1}}, {M{1'b0}}};
         w_ovf = 1'b1;
      end else if (w_exp_r <= ZERO_S) begin
         w_dat = {r2_sign, {(N-1){1'b0}}};
         w_unf = 1'b1;
      end
   end

   logic [N-1:0]  r3_dat;
   logic [TW-1:0] r3_tag;
   logic          r3_ovf, r3_unf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_v      <= 1'b0;
         r1_sign   <= 1'b0;
         r1_zero   <= 1'b0;
         r1_nar    <= 1'b0;
         r1_r0     <= 1'b0;
         r1_body   <= '0;
         r1_run    <= '0;
         r1_tag    <= '0;
         r2_v      <= 1'b0;
         r2_sign   <= 1'b0;
         r2_zero   <= 1'b0;
         r2_nar    <= 1'b0;
         r2_biased <= '0;
         r2_frac   <= '0;
         r2_tag    <= '0;
         r3_v      <= 1'b0;
         r3_dat    <= '0;
         r3_tag    <= '0;
         r3_ovf    <= 1'b0;
         r3_unf    <= 1'b0;
      end else begin
         if (w_rdy1) begin
            r1_v <= in_valid;
            if (in_valid) begin
               r1_sign <= in_data[N-1];
               r1_zero <= w_zero;
               r1_nar  <= w_nar;
               r1_r0   <= w_body[N-2];
               r1_body <= w_body;
               r1_run  <= w_run;
               r1_tag  <= in_tag;
            end
         end
         if (w_rdy2) begin
            r2_v <= r1_v;
            if (r1_v) begin
               r2_sign   <= r1_sign;
               r2_zero   <= r1_zero;
               r2_nar    <= r1_nar;
               r2_biased <= w_biased;
               r2_frac   <= w_frac;
               r2_tag    <= r1_tag;
            end
         end
         if (w_rdy3) begin
            r3_v <= r2_v;
            if (r2_v) begin
               r3_dat <= w_dat;
               r3_tag <= r2_tag;
               r3_ovf <= w_ovf;
               r3_unf <= w_unf;
            end
         end
      end
   end

   assign out_valid = r3_v;
   assign out_data  = r3_dat;
   assign out_tag   = r3_tag;
   assign out_ovf   = r3_ovf;
   assign out_unf   = r3_unf;

endmodule

// File: tb/tb_posit_to_fp_pipe.sv
// Scoreboard bench for posit_to_fp_pipe (N=32, es=3, E=8): known posit/float pairs, backpressure, streaming, reset.
`timescale 1ns/1ps
module tb_posit_to_fp_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
   logic        out_ovf, out_unf;

   posit_to_fp_pipe #(.N(32), .es(3), .E(8), .TW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .out_ovf(out_ovf), .out_unf(out_unf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  t;
      logic        o;
      logic        u;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] vp[20];
   logic [31:0] vf[20];
   logic        vo[20];
   logic        vu[20];
   int n_chk = 0, n_pass = 0;
   int cyc = 0, n_acc = 0, n_out = 0, n_stall = 0;
   bit rnd_done = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (sb.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_tag", 32'(out_tag), 32'(e.t));
            chk("out_ovf", 32'(out_ovf), 32'(e.o));
            chk("out_unf", 32'(out_unf), 32'(e.u));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the transfer edge.
   task automatic send(input int idx, input logic [3:0] t, input bit count_stall);
      int w;
      w        = 0;
      in_valid = 1'b1;
      in_data  = vp[idx];
      in_tag   = t;
      @(negedge clk);
      while (!in_ready && w < 60) begin
         w++;
         if (count_stall) n_stall++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         sb.push_back({vf[idx], t, vo[idx], vu[idx]});
         n_acc++;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic lat_check(input int idx, input logic [3:0] t);
      out_ready = 1'b1;
      send(idx, t, 1'b0);
      chk("lat_edge1_vld", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_edge2_vld", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_edge3_vld", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 400) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t0;
      vp = '{32'h40000000, 32'hC0000000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
             32'h00000001, 32'hFFFFFFFF, 32'h40000007, 32'h40000004, 32'h4000000C,
             32'h48000000, 32'h60000000, 32'h3C000000, 32'hBC000000, 32'h40400000,
             32'h7FFFB800, 32'h7FFFC000, 32'h00005000, 32'h00004800, 32'h43FFFFFF};
      vf = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7FC00000, 32'h7F800000,
             32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h3F800001,
             32'h40800000, 32'h43800000, 32'h3F000000, 32'hC0000000, 32'h3F880000,
             32'h7F000000, 32'h7F800000, 32'h00800000, 32'h00000000, 32'h3FFFFFFF};
`ifdef POSIT2FP_RNE_EN
      vf[7]  = 32'h3F800001;
      vf[9]  = 32'h3F800002;
      vf[19] = 32'h40000000;
`endif
      foreach (vo[i]) begin
         vo[i] = 1'b0;
         vu[i] = 1'b0;
      end
      vo[4] = 1'b1; vo[16] = 1'b1;
      vu[5] = 1'b1; vu[6] = 1'b1; vu[18] = 1'b1;

      // reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_out_unf", 32'(out_unf), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      lat_check(0, 4'h1);

      // every known vector, back to back
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) send(i, 4'(i), 1'b0);
      drain();

      // backpressure: only three words fit while the output is stalled
      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            for (int i = 0; i < 5; i++) send(i, 4'(i), 1'b0);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            chk("bp_accepted", 32'(n_acc - base), 32'd3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_tag", 32'(out_tag), 32'd0);
            chk("bp_hold_data", out_data, vf[0]);
            repeat (4) @(posedge clk);
            #1;
            chk("bp_hold_tag2", 32'(out_tag), 32'd0);
            chk("bp_hold_data2", out_data, vf[0]);
            chk("bp_in_ready2", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
         end
      join
      drain();

      // 100 words streamed with the output always ready
      n_stall = 0;
      base    = n_out;
      t0      = cyc;
      for (int i = 0; i < 100; i++) send(i % 20, 4'(i), 1'b1);
      chk("stream_stalls", 32'(n_stall), 32'd0);
      chk("stream_cycles", 32'(cyc - t0), 32'd100);
      drain();
      chk("stream_outputs", 32'(n_out - base), 32'd100);

      // random output backpressure
      base     = n_out;
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) send((i * 7) % 20, 4'(i), 1'b0);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("rnd_outputs", 32'(n_out - base), 32'd40);

      // reset with a full pipe
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(10 + i, 4'(8 + i), 1'b0);
      @(negedge clk);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", out_data, 32'd0);
      chk("async_rst_tag", 32'(out_tag), 32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      base      = n_out;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_no_stale", 32'(n_out - base), 32'd0);
      lat_check(11, 4'hA);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
